// File: rtl/stream_mux_n.sv
// N-channel harvest mux: walks the masked channels in ascending order and forwards
// each one's stream to the single output while that channel reports.
module stream_mux_n #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_CHAN = 4,
    parameter int unsigned TIMEOUT  = 1024,
    localparam int unsigned SEL_W   = $clog2(NUM_CHAN)
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [NUM_CHAN*WIDTH-1:0] din,
    input  logic [NUM_CHAN-1:0]       din_valid,
    output logic [NUM_CHAN-1:0]       din_ready,
    input  logic [NUM_CHAN-1:0]       reporting_in,
    input  logic [NUM_CHAN-1:0]       chan_mask,
    input  logic                      start_harvest,
    output logic                      reporting,
    output logic                      harvest_done,
    output logic [NUM_CHAN-1:0]       timeout_flags,
    output logic [SEL_W-1:0]          cur_chan,
    input  logic                      dout_ready,
    output logic                      dout_valid,
    output logic [WIDTH-1:0]          dout
);

    localparam int unsigned TMR_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned TMR_W   = (TMR_RAW < 1) ? 1 : TMR_RAW;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(NUM_CHAN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        WAIT_REP,
        WAIT_NOTREP,
        ADVANCE,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 ena_q, ena_d;
    logic [NUM_CHAN-1:0]  mask_q, mask_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [NUM_CHAN-1:0]  flags_q, flags_d;
    logic                 done_q, done_d;

    logic [NUM_CHAN-1:0]  sel_oh;
    logic                 mask_sel;
    logic                 rep_sel;
    logic                 valid_sel;

    // Decode the selected channel once; everything downstream uses the one-hot form.
    always_comb begin
        sel_oh    = '0;
        dout      = din[WIDTH-1:0];
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_oh[i] = 1'b1;
                dout      = din[i*WIDTH +: WIDTH];
            end
        end
        mask_sel  = |(mask_q & sel_oh);
        rep_sel   = |(reporting_in & sel_oh);
        valid_sel = |(din_valid & sel_oh);
        din_ready = (ena_q && dout_ready) ? sel_oh : '0;
    end

    assign dout_valid    = ena_q & valid_sel;
    assign cur_chan      = sel_q;
    assign reporting     = (state_q != IDLE);
    assign harvest_done  = done_q;
    assign timeout_flags = flags_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ena_d   = ena_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ena_d = 1'b0;
                if (start_harvest) begin
                    mask_d  = chan_mask;
                    sel_d   = '0;
                    flags_d = '0;
                    state_d = SEEK;
                end
            end
            SEEK: begin
                if (mask_sel) begin
                    ena_d   = 1'b1;
                    timer_d = '0;
                    state_d = WAIT_REP;
                end else if (sel_q == LAST_CHAN) begin
                    state_d = DONE;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end
            WAIT_REP: begin
                // A rising report beats an expiring timer in the same cycle.
                if (rep_sel) begin
                    state_d = WAIT_NOTREP;
                end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
                    flags_d = flags_q | sel_oh;
                    state_d = ADVANCE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_NOTREP: begin
                if (!rep_sel) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                ena_d = 1'b0;
                if (sel_q == LAST_CHAN) begin
                    state_d = DONE;
                end else begin
                    sel_d   = sel_q + SEL_W'(1);
                    state_d = SEEK;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                sel_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ena_q   <= 1'b0;
            mask_q  <= '0;
            timer_q <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ena_q   <= ena_d;
            mask_q  <= mask_d;
            timer_q <= timer_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: a procedural harvest model checked every cycle,
// plus literal expectations for word order, timeouts, pulse timing and reset.
module tb_stream_mux_n;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned SW = 2;

    logic             clk = 1'b0;
    logic             arst_n;
    logic [N*W-1:0]   din;
    logic [N-1:0]     din_valid, din_ready, reporting_in, chan_mask, timeout_flags;
    logic             start_harvest, reporting, harvest_done, dout_ready, dout_valid;
    logic [SW-1:0]    cur_chan;
    logic [W-1:0]     dout;

    always #5 clk = ~clk;

    stream_mux_n #(.WIDTH(W), .NUM_CHAN(N), .TIMEOUT(TO)) dut (
        .clk(clk), .arst_n(arst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .reporting_in(reporting_in), .chan_mask(chan_mask), .start_harvest(start_harvest),
        .reporting(reporting), .harvest_done(harvest_done), .timeout_flags(timeout_flags),
        .cur_chan(cur_chan), .dout_ready(dout_ready), .dout_valid(dout_valid), .dout(dout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- channel sources and report responders ----------------
    int  cnt[N];
    int  nw[N];
    int  rep_left[N];
    bit  rep_used[N];
    bit  never_rep[N];
    bit  xfer[N];
    int  rep_len;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] exp_q[$];
    int  seq_q[$];
    int  dr13;
    int  sel1;

    function automatic void drive();
        for (int i = 0; i < N; i++) begin
            din[i*W +: W]   = W'((i << 4) | cnt[i]);
            din_valid[i]    = (cnt[i] < nw[i]);
            reporting_in[i] = (rep_left[i] > 0);
        end
    endfunction

    function automatic void reset_src(input int len);
        rep_len = len;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; nw[i] = 3; rep_left[i] = 0; rep_used[i] = 1'b0; never_rep[i] = 1'b0;
        end
        sb_q.delete(); seq_q.delete(); dr13 = 0; sel1 = 0;
        drive();
    endfunction

    // Pre-edge sampling of handshakes and observed output words.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) xfer[i] = din_ready[i] & din_valid[i];
        if (arst_n === 1'b1) begin
            if (dout_valid && dout_ready) sb_q.push_back(dout);
            if (reporting) begin
                if (seq_q.size() == 0 || seq_q[$] != int'(cur_chan)) seq_q.push_back(int'(cur_chan));
                if (din_ready[1] | din_ready[3]) dr13++;
                if (cur_chan == SW'(1)) sel1++;
            end
        end
    end

    // A channel raises reporting_in for rep_len cycles from the first cycle it is selected.
    always begin
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) cnt[i]++;
            if (rep_left[i] > 0) rep_left[i]--;
            if (reporting && cur_chan == SW'(i) && !rep_used[i] && !never_rep[i]) begin
                rep_used[i] = 1'b1;
                rep_left[i] = rep_len;
            end
        end
        drive();
    end

    // ---------------- behavioural model ----------------
    logic [N-1:0]  m_mask, exp_flags;
    logic [SW-1:0] exp_sel;
    logic          exp_ena, exp_rep, exp_done;
    bit            abort;

    task automatic mtick();
        @(posedge clk);
        if (!arst_n) abort = 1'b1;
    endtask

    // One harvest: visit each channel, wait for its report to rise and fall (or time out).
    task automatic harvest();
        int t;
        int phase;
        m_mask = chan_mask; exp_flags = '0; exp_rep = 1'b1; exp_done = 1'b0;
        for (int c = 0; c < N; c++) begin
            exp_sel = SW'(c); exp_ena = 1'b0;
            mtick(); if (abort) return;
            if (m_mask[c]) begin
                exp_ena = 1'b1; t = 0; phase = 0;
                while (phase != 2) begin
                    mtick(); if (abort) return;
                    if (phase == 0) begin
                        if (reporting_in[c]) phase = 1;
                        else if (t == TO - 1) begin exp_flags[c] = 1'b1; phase = 2; end
                        else t++;
                    end else if (!reporting_in[c]) begin
                        phase = 2;
                    end
                end
                mtick(); if (abort) return;
                exp_ena = 1'b0;
            end
        end
        mtick(); if (abort) return;
        exp_rep = 1'b0; exp_sel = '0; exp_done = 1'b1;
    endtask

    initial begin
        exp_flags = '0; exp_sel = '0; exp_ena = 1'b0; exp_rep = 1'b0; exp_done = 1'b0; abort = 1'b0;
        forever begin
            @(posedge clk);
            exp_done = 1'b0;
            if (!arst_n) abort = 1'b1;
            else if (start_harvest) harvest();
            if (abort) begin
                abort = 1'b0; exp_flags = '0; exp_sel = '0; exp_ena = 1'b0; exp_rep = 1'b0; exp_done = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (arst_n === 1'b1) begin
            chk("reporting", 64'(reporting), 64'(exp_rep));
            chk("harvest_done", 64'(harvest_done), 64'(exp_done));
            chk("timeout_flags", 64'(timeout_flags), 64'(exp_flags));
            chk("cur_chan", 64'(cur_chan), 64'(exp_sel));
            chk("dout_valid", 64'(dout_valid), 64'(exp_ena & din_valid[exp_sel]));
            chk("din_ready", 64'(din_ready), (exp_ena && dout_ready) ? (64'd1 << exp_sel) : 64'd0);
            if (exp_ena && din_valid[exp_sel]) chk("dout", 64'(dout), 64'(din[int'(exp_sel)*W +: W]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start(input logic [N-1:0] mask);
        chan_mask = mask; start_harvest = 1'b1;
        cyc(1);
        start_harvest = 1'b0; chan_mask = ~mask;
    endtask

    task automatic wait_done(input string name, input bit toggle, output int rep_cycles);
        int dones;
        rep_cycles = 0; dones = 0;
        for (int k = 0; k < 400; k++) begin
            if (reporting) rep_cycles++;
            if (harvest_done) begin
                dones++;
                chk({name, "_rep_at_done"}, 64'(reporting), 64'd0);
                break;
            end
            if (toggle) dout_ready = ~dout_ready;
            cyc(1);
        end
        chk({name, "_done_seen"}, 64'(dones), 64'd1);
        dout_ready = 1'b1;
        cyc(1);
        chk({name, "_done_once"}, 64'(harvest_done), 64'd0);
    endtask

    task automatic check_sb(input string name);
        chk({name, "_count"}, 64'(sb_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sb_q.size(); i++)
            chk({name, "_word"}, 64'(sb_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        int rc;
        int dsum;
        arst_n = 1'b0; start_harvest = 1'b0; chan_mask = '0; dout_ready = 1'b1;
        reset_src(5);
        #1;
        chk("rst_reporting", 64'(reporting), 64'd0);
        chk("rst_din_ready", 64'(din_ready), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_flags", 64'(timeout_flags), 64'd0);
        repeat (2) @(posedge clk);
        #2; arst_n = 1'b1;
        cyc(5);
        chk("idle_reporting", 64'(reporting), 64'd0);

        // full harvest, all channels
        reset_src(5);
        start(4'b1111);
        wait_done("full", 1'b0, rc);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
        check_sb("full");

        // masked harvest
        reset_src(5);
        start(4'b0101);
        wait_done("masked", 1'b0, rc);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h20, 8'h21, 8'h22};
        check_sb("masked");
        chk("masked_seq_len", 64'(seq_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < seq_q.size(); i++) chk("masked_seq", 64'(seq_q[i]), 64'(i));
        chk("masked_ready13", 64'(dr13), 64'd0);

        // channel 1 never reports
        reset_src(5);
        never_rep[1] = 1'b1; nw[1] = 0; drive();
        start(4'b1111);
        wait_done("tmo", 1'b0, rc);
        chk("tmo_sel1_cycles", 64'(sel1), 64'd18);
        chk("tmo_flags", 64'(timeout_flags), 64'b0010);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
        check_sb("tmo");
        cyc(3);
        chk("tmo_flags_sticky", 64'(timeout_flags), 64'b0010);

        // backpressure
        reset_src(10);
        start(4'b0011);
        wait_done("bp", 1'b1, rc);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
        check_sb("bp");

        // empty mask
        reset_src(5);
        start(4'b0000);
        wait_done("mask0", 1'b0, rc);
        chk("mask0_rep_cycles", 64'(rc), 64'd5);

        // start_harvest during a harvest is ignored
        reset_src(5);
        start(4'b0001);
        cyc(2);
        chan_mask = 4'b1110; start_harvest = 1'b1;
        cyc(1);
        start_harvest = 1'b0;
        wait_done("midstart", 1'b0, rc);
        exp_q = '{8'h00, 8'h01, 8'h02};
        check_sb("midstart");
        cyc(2);
        chk("midstart_not_queued", 64'(reporting), 64'd0);

        // reset mid-harvest after a timeout flag is set
        reset_src(5);
        never_rep[1] = 1'b1; nw[1] = 0; drive();
        start(4'b1111);
        for (int k = 0; k < 100 && !timeout_flags[1]; k++) cyc(1);
        chk("rstmid_flag_set", 64'(timeout_flags[1]), 64'd1);
        arst_n = 1'b0;
        #1;
        chk("rstmid_reporting", 64'(reporting), 64'd0);
        chk("rstmid_flags", 64'(timeout_flags), 64'd0);
        chk("rstmid_dout_valid", 64'(dout_valid), 64'd0);
        chk("rstmid_din_ready", 64'(din_ready), 64'd0);
        cyc(2);
        arst_n = 1'b1;
        dsum = 0;
        for (int k = 0; k < 6; k++) begin
            dsum += int'(harvest_done);
            cyc(1);
        end
        chk("rstmid_no_done", 64'(dsum), 64'd0);
        chk("rstmid_idle", 64'(reporting), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- N-channel successor to the two-port harvest mux in the debug path.
- On each harvest request, visits every enabled channel in ascending index order and forwards that channel's stream to the single output while the channel reports.
- Adds a per-harvest channel mask, a per-channel no-response timeout, sticky timeout flags and a harvest-done pulse.
- Sits between the debug capture/report sources and the single debug output stream.

Parameters:
- WIDTH, 8, data width per channel.
- NUM_CHAN, 4, number of input channels (>=2).
- TIMEOUT, 1024, cycles to wait for reporting to rise on a channel; 0 disables the timeout.

Ports:
- clk  input  1  clock.
- arst_n  input  1  asynchronous active-low reset.
- din  input  NUM_CHAN*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- din_valid  input  NUM_CHAN  per-channel valid.
- din_ready  output  NUM_CHAN  per-channel ready.
- reporting_in  input  NUM_CHAN  per-channel "report in progress".
- chan_mask  input  NUM_CHAN  channels to harvest; sampled only on an accepted start_harvest.
- start_harvest  input  1  harvest request.
- reporting  output  1  high whenever a harvest is in progress.
- harvest_done  output  1  one-cycle pulse at harvest end.
- timeout_flags  output  NUM_CHAN  sticky per-channel timeout indicators.
- cur_chan  output  SEL_W  currently selected channel, where SEL_W = $clog2(NUM_CHAN).
- dout_ready  input  1  downstream ready.
- dout_valid  output  1  output valid.
- dout  output  WIDTH  output data.

Behaviour:
- Reset (arst_n low, asynchronous):
  - state=IDLE, sel=0, ena=0, mask_q=0, timer=0, timeout_flags=0, harvest_done=0.
  - Combinationally, din_ready=0 and dout_valid=0.
- Datapath (combinational):
  - dout = din[sel*WIDTH +: WIDTH].
  - dout_valid = ena & din_valid[sel].
  - din_ready[i] = ena & (sel==i) & dout_ready.
  - cur_chan = sel.
  - reporting = (state != IDLE).
  - A transfer occurs on cycles where dout_valid & dout_ready.
- IDLE:
  - ena=0.
  - On start_harvest: mask_q<=chan_mask, sel<=0, timeout_flags<=0, go to SEEK.
- SEEK:
  - If mask_q[sel]: ena<=1, timer<=0, go to WAIT_REP.
  - Else if sel==NUM_CHAN-1: go to DONE.
  - Else: sel<=sel+1, stay in SEEK. The scan costs one cycle per skipped channel.
- WAIT_REP (ena=1):
  - If reporting_in[sel]: go to WAIT_NOTREP. reporting_in has priority over timeout in the same cycle.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1: timeout_flags[sel]<=1, go to ADVANCE.
  - Else: timer<=timer+1.
- WAIT_NOTREP (ena=1):
  - If !reporting_in[sel]: go to ADVANCE.
  - No timeout applies in this state.
- ADVANCE:
  - ena<=0.
  - If sel==NUM_CHAN-1: go to DONE.
  - Else: sel<=sel+1, go to SEEK.
- DONE:
  - harvest_done<=1 (registered, so it is high the cycle after DONE).
  - sel<=0, go to IDLE.
- Pulse timing: harvest_done is high in the same cycle reporting first reads 0.
- Boundary conditions:
  - start_harvest is ignored outside IDLE; it is not queued.
  - chan_mask changes during a harvest have no effect.
  - chan_mask all zero: SEEK walks all channels, then DONE. reporting stays high for NUM_CHAN+1 cycles, then harvest_done pulses.
  - reporting_in already high on entry to WAIT_REP: advances to WAIT_NOTREP on the next edge.
  - Data from a channel is passed only while ena=1. Channels not selected see din_ready=0.
  - Reset mid-harvest aborts immediately with no harvest_done pulse. timeout_flags clear.
  - timeout_flags remain readable after harvest_done until the next accepted start_harvest.
- Widths:
  - timer width is $clog2(TIMEOUT+1), minimum 1.
  - sel increments never exceed NUM_CHAN-1.

Test Plan:
1. Reset then idle: arst_n low, then release with start_harvest=0 -> reporting=0, din_ready=0, dout_valid=0, timeout_flags=0 throughout.
2. Full harvest, NUM_CHAN=4, mask=4'b1111: each channel raises reporting_in for 5 cycles and sends 3 words with dout_ready=1 -> dout carries words in channel order 0,1,2,3; harvest_done pulses once; reporting falls together with it.
3. Masked harvest, mask=4'b0101: -> only channels 0 and 2 are ever selected; din_ready[1] and din_ready[3] stay 0; cur_chan sequence 0,1,2,3 during SEEK/ADVANCE.
4. Timeout, TIMEOUT=16, channel 1 never reports: -> channel 1 is abandoned after exactly 16 WAIT_REP cycles; timeout_flags=4'b0010 after harvest_done; channels 2 and 3 are still harvested.
5. Backpressure: dout_ready toggling 1,0,1,0 with din_valid held high -> din_ready[sel] mirrors dout_ready; no word is lost or duplicated.
6. Corner cases:
   - Mask 0 -> reporting high for exactly NUM_CHAN+1 cycles, then harvest_done.
   - start_harvest mid-harvest -> ignored.
   - arst_n pulsed mid-harvest -> state IDLE immediately, no harvest_done.
